// File: rtl/top.sv
// HD44780 "hello" sequencer: replays the LCD port traffic of a 65C02
// hello-world program driving the display through a 6522 port.
// pa[7]=E, pa[6]=RW, pa[5]=RS, pa[4:0]=0; pb is the bidirectional data bus.
module top #(
    parameter int STEP_CYCLES = 4
) (
    input logic       clk,
    input logic       RST,
    inout logic [7:0] pa,
    inout logic [7:0] pb
);

    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);
    localparam logic [4:0] LAST_BYTE = 5'd16;

    typedef enum logic [2:0] {
        CHK_SETUP,
        CHK_EHI,
        CHK_ELO,
        WR_SETUP,
        WR_EHI,
        WR_ELO,
        DONE
    } state_t;

    state_t          state;
    logic [4:0]      idx;
    logic [CW-1:0]   cnt;
    logic            busy;
    logic            e_q;
    logic            rw_q;
    logic            rs_q;
    logic            oe_q;
    logic [7:0]      dat_q;
    logic            rs_cur;

    // Byte stream: four set-up commands followed by the greeting text.
    function automatic logic [7:0] byte_at(input logic [4:0] i);
        case (i)
            5'd0:    byte_at = 8'h38;
            5'd1:    byte_at = 8'h0E;
            5'd2:    byte_at = 8'h06;
            5'd3:    byte_at = 8'h01;
            5'd4:    byte_at = 8'h48;
            5'd5:    byte_at = 8'h65;
            5'd6:    byte_at = 8'h6C;
            5'd7:    byte_at = 8'h6C;
            5'd8:    byte_at = 8'h6F;
            5'd9:    byte_at = 8'h2C;
            5'd10:   byte_at = 8'h20;
            5'd11:   byte_at = 8'h77;
            5'd12:   byte_at = 8'h6F;
            5'd13:   byte_at = 8'h72;
            5'd14:   byte_at = 8'h6C;
            5'd15:   byte_at = 8'h64;
            5'd16:   byte_at = 8'h21;
            default: byte_at = 8'h00;
        endcase
    endfunction

    assign rs_cur = (idx >= 5'd4);

    assign pa = {e_q, rw_q, rs_q, 5'b00000};
    assign pb = oe_q ? dat_q : 'z;

    // Phase sequencer. Outputs are registered from the phase held before each
    // edge, so every phase appears on the pins for exactly STEP_CYCLES cycles
    // starting on the first edge after reset is released.
    always_ff @(posedge clk) begin
        if (RST) begin
            state <= CHK_SETUP;
            idx   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            e_q   <= 1'b0;
            rw_q  <= 1'b0;
            rs_q  <= 1'b0;
            oe_q  <= 1'b0;
            dat_q <= '0;
        end else begin
            dat_q <= byte_at(idx);
            case (state)
                CHK_SETUP: begin e_q <= 1'b0; rw_q <= 1'b1; rs_q <= 1'b0;   oe_q <= 1'b0; end
                CHK_EHI:   begin e_q <= 1'b1; rw_q <= 1'b1; rs_q <= 1'b0;   oe_q <= 1'b0; end
                CHK_ELO:   begin e_q <= 1'b0; rw_q <= 1'b1; rs_q <= 1'b0;   oe_q <= 1'b0; end
                WR_SETUP:  begin e_q <= 1'b0; rw_q <= 1'b0; rs_q <= rs_cur; oe_q <= 1'b1; end
                WR_EHI:    begin e_q <= 1'b1; rw_q <= 1'b0; rs_q <= rs_cur; oe_q <= 1'b1; end
                WR_ELO:    begin e_q <= 1'b0; rw_q <= 1'b0; rs_q <= rs_cur; oe_q <= 1'b1; end
                default:   begin e_q <= 1'b0; rw_q <= 1'b0; rs_q <= 1'b0;   oe_q <= 1'b0; end
            endcase

            if (state != DONE) begin
                if (cnt == LAST) begin
                    cnt <= '0;
                    case (state)
                        CHK_SETUP: state <= CHK_EHI;
                        CHK_EHI: begin
                            state <= CHK_ELO;
                            // Only a solid 1 on D7 means busy; X/Z read as ready.
                            if (pb[7]) busy <= 1'b1;
                            else       busy <= 1'b0;
                        end
                        CHK_ELO:   state <= busy ? CHK_SETUP : WR_SETUP;
                        WR_SETUP:  state <= WR_EHI;
                        WR_EHI:    state <= WR_ELO;
                        WR_ELO: begin
                            if (idx == LAST_BYTE) begin
                                state <= DONE;
                            end else begin
                                idx   <= idx + 5'd1;
                                state <= CHK_SETUP;
                            end
                        end
                        default:   state <= DONE;
                    endcase
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_top.sv
// Bench for the HD44780 hello sequencer: a per-cycle trace model built from
// the byte list and phase rules, a compare process, and a latch monitor.
module tb_top;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       RST;
    wire  [7:0] pa;
    wire  [7:0] pb;
    logic       tb_drv;
    logic [7:0] tb_val;

    assign pb = tb_drv ? tb_val : 8'bz;

    always #5 clk = ~clk;

    top #(.STEP_CYCLES(N)) dut (
        .clk (clk),
        .RST (RST),
        .pa  (pa),
        .pb  (pb)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Expected per-cycle trace (pins after each post-reset edge)
    logic [7:0] q_pa[$];
    logic [7:0] q_pb[$];
    bit         q_drv[$];
    int         busy_plan[17];

    logic [7:0] cmds[4] = '{8'h38, 8'h0E, 8'h06, 8'h01};
    string      msg = "Hello, world!";
    logic [7:0] golden[17] = '{8'h38, 8'h0E, 8'h06, 8'h01, 8'h48, 8'h65, 8'h6C, 8'h6C,
                               8'h6F, 8'h2C, 8'h20, 8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};

    logic       exp_valid = 1'b0;
    logic [7:0] exp_pa;
    logic [7:0] exp_pb;
    string      exp_tag;

    // Released bus bits (Z/X) read as 0; the sequence never writes 0x00.
    function automatic logic [7:0] norm(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = (v[i] === 1'b1);
        return r;
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h required %02h", name, act, exp);
        end
    endtask

    task automatic checkn(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Compare process: pins vs. model on every meaningful cycle
    always @(negedge clk) begin
        if (exp_valid) begin
            check8({exp_tag, " pa"}, pa, exp_pa);
            check8({exp_tag, " pb"}, norm(pb), exp_pb);
        end
    end

    // Latch monitor: records bytes taken on each falling E
    logic [7:0] lat_q[$];
    bit         lat_rs[$];
    int         chk_pulses = 0;
    logic       prev_e = 1'b0;
    logic [7:0] hold_pb;
    logic       hold_rw = 1'b0;
    logic       hold_rs = 1'b0;

    always @(negedge clk) begin
        if (pa[7] === 1'b1) begin
            hold_pb <= norm(pb);
            hold_rw <= pa[6];
            hold_rs <= pa[5];
        end else if (prev_e) begin
            if (hold_rw) begin
                chk_pulses <= chk_pulses + 1;
            end else begin
                lat_q.push_back(hold_pb);
                lat_rs.push_back(hold_rs);
            end
        end
        prev_e <= (pa[7] === 1'b1);
    end

    task automatic push_n(input logic [7:0] a, input logic [7:0] b, input bit d);
        repeat (N) begin
            q_pa.push_back(a);
            q_pb.push_back(b);
            q_drv.push_back(d);
        end
    endtask

    task automatic build_model(input int done_cycles);
        logic [7:0] v;
        logic       rs;
        bit         bz;
        q_pa.delete();
        q_pb.delete();
        q_drv.delete();
        for (int b = 0; b < 17; b++) begin
            v  = (b < 4) ? cmds[b] : 8'(msg[b-4]);
            rs = (b >= 4);
            for (int r = 0; r <= busy_plan[b]; r++) begin
                bz = (r < busy_plan[b]);
                push_n(8'h40, bz ? 8'h80 : 8'h00, bz);
                push_n(8'hC0, bz ? 8'h80 : 8'h00, bz);
                push_n(8'h40, 8'h00, 1'b0);
            end
            push_n({2'b00, rs, 5'b0}, v, 1'b0);
            push_n({2'b10, rs, 5'b0}, v, 1'b0);
            push_n({2'b00, rs, 5'b0}, v, 1'b0);
        end
        repeat (done_cycles) begin
            q_pa.push_back(8'h00);
            q_pb.push_back(8'h00);
            q_drv.push_back(1'b0);
        end
    endtask

    task automatic run_trace(input int start, input int count, input string tag);
        for (int k = start; k < start + count; k++) begin
            @(posedge clk);
            #1;
            tb_drv    = q_drv[k];
            tb_val    = 8'h80;
            exp_pa    = q_pa[k];
            exp_pb    = q_pb[k];
            exp_tag   = $sformatf("%s[%0d]", tag, k);
            exp_valid = 1'b1;
        end
    endtask

    task automatic reset_hold(input int cycles, input string tag);
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            tb_drv    = 1'b0;
            exp_pa    = 8'h00;
            exp_pb    = 8'h00;
            exp_tag   = $sformatf("%s[%0d]", tag, k);
            exp_valid = 1'b1;
        end
    endtask

    initial begin
        RST    = 1'b1;
        tb_drv = 1'b0;
        tb_val = 8'h80;

        // Run 1: busy on byte 0 (one extra poll) and byte 9 (two extra polls)
        foreach (busy_plan[i]) busy_plan[i] = 0;
        busy_plan[0] = 1;
        busy_plan[9] = 2;
        build_model(20);

        reset_hold(10, "reset");
        RST = 1'b0;

        run_trace(0, 1, "run1");
        @(negedge clk);
        check8("lit first CHK_SETUP pa", pa, 8'h40);
        check8("lit first CHK_SETUP pb", norm(pb), 8'h80);
        run_trace(1, 4, "run1");
        @(negedge clk);
        check8("lit first CHK_EHI pa", pa, 8'hC0);
        run_trace(5, 4, "run1");
        @(negedge clk);
        check8("lit first CHK_ELO pb", norm(pb), 8'h00);
        run_trace(9, 20, "run1");
        @(negedge clk);
        check8("lit first WR_EHI pa", pa, 8'h80);
        check8("lit first WR_EHI pb", norm(pb), 8'h38);
        run_trace(29, q_pa.size() - 29, "run1");
        @(negedge clk);

        checkn("write pulses", lat_q.size(), 17);
        checkn("busy-check pulses", chk_pulses, 20);
        for (int i = 0; i < 17; i++) begin
            if (i < lat_q.size()) begin
                check8($sformatf("latched byte %0d", i), lat_q[i], golden[i]);
                checkn($sformatf("latched rs %0d", i), int'(lat_rs[i]), (i >= 4) ? 1 : 0);
            end
        end

        // Run 2: no busy; reset during the 5th data write ('o', byte 8)
        foreach (busy_plan[i]) busy_plan[i] = 0;
        build_model(0);
        RST = 1'b1;
        reset_hold(3, "rerst");
        RST = 1'b0;
        lat_q.delete();
        lat_rs.delete();
        run_trace(0, 8 * 24 + 18, "run2");
        RST = 1'b1;
        reset_hold(3, "abort");
        lat_q.delete();
        lat_rs.delete();
        RST = 1'b0;
        run_trace(0, 30, "restart");
        @(negedge clk);
        exp_valid = 1'b0;
        checkn("restart writes", lat_q.size(), 1);
        if (lat_q.size() > 0) check8("restart first byte", lat_q[0], 8'h38);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 The module SHALL have one parameter, STEP_CYCLES, default 4, giving the clk cycles each bus phase is held.
REQ-002 The module SHALL have port clk, input, 1 bit, the system clock; all state updates on its rising edge.
REQ-003 The module SHALL have port RST, input, 1 bit, a synchronous active-high reset.
REQ-004 The module SHALL have port pa, inout, 8 bits, the LCD control port: pa[7]=E, pa[6]=RW, pa[5]=RS, pa[4:0] always driven 0; pa is always driven by top.
REQ-005 The module SHALL have port pb, inout, 8 bits, the LCD data bus: driven by top only during write transactions, high-Z otherwise.

Function
REQ-006 top SHALL be a self-contained HD44780 "hello" sequencer that emits the same LCD port traffic as a 65C02 running a hello-world program through a 6522 port.
REQ-007 Sequence: 0x38, 0x0E, 0x06, 0x01 as commands (RS=0), then the 13 ASCII bytes "Hello, world!" (0x48 0x65 0x6C 0x6C 0x6F 0x2C 0x20 0x77 0x6F 0x72 0x6C 0x64 0x21) as data (RS=1), then DONE.
REQ-008 Every write SHALL be preceded by a busy check; no write SHALL start until a busy check reads not-busy.
REQ-009 Each phase below SHALL last exactly STEP_CYCLES clk cycles.
REQ-010 Busy check, three phases, pb high-Z throughout: CHK_SETUP pa[7:5]=010; CHK_EHI pa[7:5]=110; CHK_ELO pa[7:5]=010.
REQ-011 pb[7] SHALL be sampled on the last clk edge of CHK_EHI; busy only when the sampled value is 1 (0, X or Z = not busy).
REQ-012 After CHK_ELO: if busy, go to CHK_SETUP again; if not busy, go to WR_SETUP.
REQ-013 Write, three phases, pb driven with the current byte in all three: WR_SETUP pa[7:5]={0,0,RS}; WR_EHI pa[7:5]={1,0,RS}; WR_ELO pa[7:5]={0,0,RS}.
REQ-014 After WR_ELO: release pb to high-Z, then advance to the next byte's CHK_SETUP, or to DONE after byte 17.
REQ-015 DONE SHALL be terminal: pa=0x00, pb high-Z, held until RST.
REQ-016 pb SHALL be released before RW goes to 1, and SHALL not be driven in any cycle where pa[6]=1.
REQ-017 E SHALL change only at phase boundaries; RS, RW and pb data SHALL be stable across each E-high phase.
REQ-018 The busy-poll loop SHALL be unbounded, with no timeout.
REQ-019 State set: CHK_SETUP, CHK_EHI, CHK_ELO, WR_SETUP, WR_EHI, WR_ELO, DONE, plus a 5-bit byte index (0..16) and a phase-cycle counter.

Reset
REQ-020 While RST=1 at a clk edge: pa=0x00, pb high-Z, byte index=0, cycle counter=0, and state becomes CHK_SETUP, first entered on the first edge with RST=0.
REQ-021 RST asserted mid-sequence SHALL abort any transaction: pb released and E low on the next edge, and the sequence restarts from command 0x38.

Verification
REQ-022 Hold RST=1 for 10 cycles -> pa=0x00 and pb=Z on every cycle.
REQ-023 Release RST with pb undriven -> pa[7:5]=010 within 1 cycle, then 110 for 4 cycles, then 010 for 4 cycles, with pb=Z throughout.
REQ-024 Drive pb=0x80 from the first pa[7:5]==010 until the falling edge of pa[7], then release -> a second busy check occurs before any write, and pb is not driven by top during either check.
REQ-025 After the busy flag clears -> write 0x38 with pa[7:5]=000/100/000 for 4 cycles each and pb=0x38 throughout, then pb returns to Z.
REQ-026 Run to completion with pb undriven on reads -> exactly 17 E pulses with RW=0 latch bytes 0x38,0x0E,0x06,0x01 (RS=0) then "Hello, world!" (RS=1), then pa=0x00 and pb=Z permanently.
REQ-027 Assert RST during the 5th data write -> pa=0x00 and pb=Z on the next edge, and after release the first latched byte is 0x38.
